cellram_burst_ctrl: RTL and testbench
=====================================

CELLRAM_BURST_CTRL -- requirements
Module: cellram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 23; memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 16; data bus width.
REQ-003 SHALL have parameter BURST_LEN, default 4; words per burst; legal values 4, 8, 16.
REQ-004 SHALL have parameter LATENCY, default 3; initial access latency in clocks; legal range 2..6.
REQ-005 SHALL have port CLK, input, 1; the single clock.
REQ-006 SHALL have port RSTN, input, 1; reset, synchronous, active-low.
REQ-007 SHALL have port Start, input, 1; a one-cycle burst request.
REQ-008 SHALL have port Write, input, 1; burst direction, sampled with Start (1 = write).
REQ-009 SHALL have port AddrIn, input, ADDR_W; burst start address, sampled with Start.
REQ-010 SHALL have port WrData, input, DATA_W; write word, consumed when WrAck is high.
REQ-011 SHALL have port WrAck, output, 1; WrData was taken this cycle.
REQ-012 SHALL have port RdData, output, DATA_W; read word.
REQ-013 SHALL have port RdValid, output, 1; RdData is valid this cycle.
REQ-014 SHALL have port Busy, output, 1; high from configuration or accepted Start until Done.
REQ-015 SHALL have port Done, output, 1; one-cycle pulse at burst end.
REQ-016 SHALL have memory-side ports: MemAddr (out, ADDR_W), MemDqOut (out, DATA_W), MemDqIn (in, DATA_W), MemDqOE (out, 1), MemCRE (out, 1), MemWait (in, 1).
REQ-017 SHALL have active-low memory control outputs MemCE_n, MemWE_n, MemOE_n, MemADV_n, MemLB_n, MemUB_n, each 1 bit.

Function
REQ-018 SHALL implement states CFG_SETUP, CFG_WR, CFG_HOLD, IDLE, ADDR, LAT, XFER, FINISH.
REQ-019 After reset SHALL go to CFG_SETUP, then CFG_WR for one cycle (MemCRE=1, MemADV_n=0, MemCE_n=0, MemWE_n=0, MemAddr=BCR), then CFG_HOLD for 2 cycles, then IDLE.
REQ-020 BCR SHALL encode synchronous burst mode, LATENCY, and the BURST_LEN wrap setting, taken from the shared package function.
REQ-021 In IDLE, Start SHALL latch Write and AddrIn and move to ADDR on the next cycle; Start while Busy SHALL be ignored.
REQ-022 ADDR SHALL last 1 cycle with MemADV_n=0, MemCE_n=0, and MemWE_n=~Write.
REQ-023 LAT SHALL last LATENCY-1 cycles, counted by a $clog2(LATENCY+1)-bit counter, then go to XFER.
REQ-024 In XFER each cycle with MemWait=0 SHALL transfer one word; a cycle with MemWait=1 SHALL transfer nothing and hold the beat counter.
REQ-025 For a read transfer: RdData=MemDqIn registered, RdValid=1, MemOE_n=0, MemDqOE=0.
REQ-026 For a write transfer: WrAck=1, MemDqOut=WrData, MemDqOE=1, and MemLB_n=MemUB_n=0.
REQ-027 The beat counter SHALL be $clog2(BURST_LEN)+1 bits; after the BURST_LEN-th word, go to FINISH.
REQ-028 FINISH SHALL deassert all memory controls (high), pulse Done, and return to IDLE, giving a minimum 1-cycle CE_n-high gap between bursts.
REQ-029 Busy SHALL be low only in IDLE.
REQ-030 MemWait held high for more than 64 consecutive XFER cycles SHALL abort to FINISH, with Done pulsed.

Reset
REQ-031 When RSTN=0 at a clock edge, the block SHALL go to CFG_SETUP from any state, including mid-burst.
REQ-032 Reset values SHALL be: MemCE_n, MemWE_n, MemOE_n, MemADV_n, MemLB_n, MemUB_n = 1; MemCRE, MemDqOE, RdValid, WrAck, Done = 0; Busy = 1; MemAddr, MemDqOut, RdData = 0; all counters = 0.

Structure
REQ-033 A package cellram_pkg SHALL hold the state enum, the BCR field constants, and the function building BCR from LATENCY and BURST_LEN.
REQ-034 A single sub-module, cellram_beat_counter, SHALL hold the loadable, enable-gated counter, used for both the LAT and beat counts.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Bench SHALL cover: reset release -> CFG_WR exactly 1 cycle with MemCRE=1 and MemAddr=BCR(3,4), IDLE after 4 cycles, Busy falling after.
REQ-037 Bench SHALL cover: read with BURST_LEN=4, LATENCY=3, MemWait=0 -> 4 RdValid beats in consecutive cycles, first beat 3 cycles after ADDR, then Done.
REQ-038 Bench SHALL cover: write burst of 8 with MemWait high on beat 3 for 2 cycles -> exactly 8 WrAck pulses, none during wait, data order preserved.
REQ-039 Bench SHALL cover: Start asserted during XFER -> ignored; word count unchanged.
REQ-040 Bench SHALL cover: RSTN low during beat 2 of a read -> controls high next edge, then full reconfiguration sequence.
REQ-041 Bench SHALL cover: MemWait stuck high -> abort after 64 cycles with Done=1 and fewer than BURST_LEN RdValid beats.

Source files
------------

// File: rtl/cellram_pkg.sv
// ============================================================================
// Module : cellram_pkg
// Brief  : Shared state encoding and Bus Configuration Register (BCR) builder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cellram_pkg;

    typedef enum logic [2:0] {
        CFG_SETUP,
        CFG_WR,
        CFG_HOLD,
        IDLE,
        ADDR,
        LAT,
        XFER,
        FINISH
    } state_t;

    localparam int         c_bcr_w            = 23;
    localparam int         c_bcr_reg_sel_lsb  = 18;
    localparam logic [1:0] c_bcr_reg_sel      = 2'b10;
    localparam int         c_bcr_mode_bit     = 15;
    localparam logic       c_bcr_mode_sync    = 1'b0;
    localparam int         c_bcr_lat_lsb      = 11;
    localparam int         c_bcr_wait_pol_bit = 10;
    localparam logic       c_bcr_wait_pol_hi  = 1'b1;
    localparam int         c_bcr_wrap_bit     = 3;
    localparam logic       c_bcr_wrap_on      = 1'b0;
    localparam int         c_wait_limit       = 64;

    // Burst-length code: 4 -> 001, 8 -> 010, 16 -> 011; latency code equals the clock count.
    function automatic logic [c_bcr_w-1:0] bcr_value(input int latency, input int burst_len);
        logic [c_bcr_w-1:0] v;
        logic [2:0]         len_code;
        case (burst_len)
            8:       len_code = 3'b010;
            16:      len_code = 3'b011;
            default: len_code = 3'b001;
        endcase
        v                             = '0;
        v[c_bcr_reg_sel_lsb +: 2]     = c_bcr_reg_sel;
        v[c_bcr_mode_bit]             = c_bcr_mode_sync;
        v[c_bcr_lat_lsb +: 3]         = 3'(latency);
        v[c_bcr_wait_pol_bit]         = c_bcr_wait_pol_hi;
        v[c_bcr_wrap_bit]             = c_bcr_wrap_on;
        v[2:0]                        = len_code;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cellram_beat_counter.sv
// ============================================================================
// Module : cellram_beat_counter
// Brief  : Loadable, enable-gated up-counter shared by latency, beat and wait counts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cellram_beat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/cellram_burst_ctrl.sv
// ============================================================================
// Module : cellram_burst_ctrl
// Brief  : CellRAM synchronous burst controller with power-up BCR configuration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cellram_burst_ctrl
    import cellram_pkg::*;
#(
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int LATENCY   = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              Start,
    input  logic              Write,
    input  logic [ADDR_W-1:0] AddrIn,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrAck,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDqOut,
    input  logic [DATA_W-1:0] MemDqIn,
    output logic              MemDqOE,
    output logic              MemCRE,
    input  logic              MemWait,
    output logic              MemCE_n,
    output logic              MemWE_n,
    output logic              MemOE_n,
    output logic              MemADV_n,
    output logic              MemLB_n,
    output logic              MemUB_n
);

    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int WAIT_W = $clog2(c_wait_limit + 1);

    localparam logic [ADDR_W-1:0] c_bcr       = ADDR_W'(bcr_value(LATENCY, BURST_LEN));
    localparam logic [LAT_W-1:0]  c_lat_last  = LAT_W'(LATENCY - 2);
    localparam logic [LAT_W-1:0]  c_hold_last = LAT_W'(1);
    localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(BURST_LEN - 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(c_wait_limit);

    state_t              r_state;
    logic                r_write;
    logic [LAT_W-1:0]    w_lat_cnt;
    logic [BEAT_W-1:0]   w_beat_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt;
    logic                w_in_xfer;
    logic                w_beat;
    logic                w_stall;

    assign w_in_xfer = (r_state == XFER);
    assign w_beat    = w_in_xfer && !MemWait;
    assign w_stall   = w_in_xfer && MemWait;

    // The latency counter also times the two CFG_HOLD cycles.
    cellram_beat_counter #(.WIDTH(LAT_W)) u_lat_cnt (
        .clk      (CLK),
        .rstn     (RSTN),
        .load     ((r_state == CFG_WR) || (r_state == ADDR)),
        .load_val ('0),
        .en       ((r_state == CFG_HOLD) || (r_state == LAT)),
        .count    (w_lat_cnt)
    );

    cellram_beat_counter #(.WIDTH(BEAT_W)) u_beat_cnt (
        .clk      (CLK),
        .rstn     (RSTN),
        .load     (r_state == ADDR),
        .load_val ('0),
        .en       (w_beat),
        .count    (w_beat_cnt)
    );

    // Counts consecutive stalled XFER cycles; any other cycle clears it.
    cellram_beat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk      (CLK),
        .rstn     (RSTN),
        .load     (!w_stall),
        .load_val ('0),
        .en       (w_stall),
        .count    (w_wait_cnt)
    );

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state  <= CFG_SETUP;
            r_write  <= 1'b0;
            MemCE_n  <= 1'b1;
            MemWE_n  <= 1'b1;
            MemOE_n  <= 1'b1;
            MemADV_n <= 1'b1;
            MemLB_n  <= 1'b1;
            MemUB_n  <= 1'b1;
            MemCRE   <= 1'b0;
            MemDqOE  <= 1'b0;
            RdValid  <= 1'b0;
            WrAck    <= 1'b0;
            Done     <= 1'b0;
            Busy     <= 1'b1;
            MemAddr  <= '0;
            MemDqOut <= '0;
            RdData   <= '0;
        end else begin
            RdValid <= 1'b0;
            WrAck   <= 1'b0;
            Done    <= 1'b0;
            case (r_state)
                CFG_SETUP: begin
                    r_state  <= CFG_WR;
                    MemCRE   <= 1'b1;
                    MemADV_n <= 1'b0;
                    MemCE_n  <= 1'b0;
                    MemWE_n  <= 1'b0;
                    MemAddr  <= c_bcr;
                end
                CFG_WR: begin
                    r_state  <= CFG_HOLD;
                    MemCRE   <= 1'b0;
                    MemADV_n <= 1'b1;
                    MemCE_n  <= 1'b1;
                    MemWE_n  <= 1'b1;
                end
                CFG_HOLD: begin
                    if (w_lat_cnt == c_hold_last) begin
                        r_state <= IDLE;
                        Busy    <= 1'b0;
                    end
                end
                IDLE: begin
                    if (Start) begin
                        r_state  <= ADDR;
                        r_write  <= Write;
                        MemAddr  <= AddrIn;
                        MemADV_n <= 1'b0;
                        MemCE_n  <= 1'b0;
                        MemWE_n  <= ~Write;
                        Busy     <= 1'b1;
                    end
                end
                ADDR: begin
                    r_state  <= LAT;
                    MemADV_n <= 1'b1;
                end
                LAT: begin
                    if (w_lat_cnt == c_lat_last) begin
                        r_state <= XFER;
                        MemOE_n <= r_write;
                        MemDqOE <= r_write;
                        MemLB_n <= 1'b0;
                        MemUB_n <= 1'b0;
                    end
                end
                XFER: begin
                    if (!MemWait) begin
                        if (r_write) begin
                            WrAck    <= 1'b1;
                            MemDqOut <= WrData;
                        end else begin
                            RdValid <= 1'b1;
                            RdData  <= MemDqIn;
                        end
                    end
                    if ((!MemWait && (w_beat_cnt == c_beat_last)) ||
                        (MemWait && (w_wait_cnt == c_wait_last))) begin
                        r_state  <= FINISH;
                        Done     <= 1'b1;
                        MemCE_n  <= 1'b1;
                        MemWE_n  <= 1'b1;
                        MemOE_n  <= 1'b1;
                        MemADV_n <= 1'b1;
                        MemLB_n  <= 1'b1;
                        MemUB_n  <= 1'b1;
                        MemDqOE  <= 1'b0;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= CFG_SETUP;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cellram_burst_ctrl.sv
// ============================================================================
// Module : tb_cellram_burst_ctrl
// Brief  : Self-checking bench; two controllers (burst 4 and burst 8, latency 3).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cellram_burst_ctrl;

    localparam int AW   = 23;
    localparam int DW   = 16;
    localparam int LAT  = 3;
    localparam int NC   = 256;
    localparam int WLIM = 64;

    typedef struct {
        logic          rstn;
        logic [9:0]    ctl;       // {CRE,CE_n,WE_n,ADV_n,OE_n,DqOE,RdValid,WrAck,Done,Busy}
        logic          chk_addr;
        logic          chk_zero;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
    } cfg_vec_t;

    logic          clk_i = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [DW-1:0] mem_dq_in = '0;
    logic          mem_wait = 1'b0;

    logic [DW-1:0] a_wr_data, b_wr_data;
    logic          a_wr_ack, b_wr_ack, a_rd_valid, b_rd_valid, a_busy, b_busy, a_done, b_done;
    logic [DW-1:0] a_rd_data, b_rd_data, a_dq_out, b_dq_out;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_dq_oe, b_dq_oe, a_cre, b_cre, a_ce_n, b_ce_n, a_we_n, b_we_n;
    logic          a_oe_n, b_oe_n, a_adv_n, b_adv_n, a_lb_n, b_lb_n, a_ub_n, b_ub_n;

    int errors = 0;
    int checks = 0;

    cfg_vec_t      cfg_tab [7];
    bit            wpat [NC];
    logic [DW-1:0] din [NC];
    logic [DW-1:0] wdata [2][16];
    bit            exp_beat [2][NC];
    int            exp_idx [2][NC];
    int            done_cyc [2];
    int            exp_cnt [2];
    int            obs_cnt [2];
    int            wr_idx [2];

    always #5 clk_i = ~clk_i;

    cellram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4), .LATENCY(LAT)) dut_a (
        .CLK(clk_i), .RSTN(rstn), .Start(start), .Write(write), .AddrIn(addr_in),
        .WrData(a_wr_data), .WrAck(a_wr_ack), .RdData(a_rd_data), .RdValid(a_rd_valid),
        .Busy(a_busy), .Done(a_done), .MemAddr(a_addr), .MemDqOut(a_dq_out),
        .MemDqIn(mem_dq_in), .MemDqOE(a_dq_oe), .MemCRE(a_cre), .MemWait(mem_wait),
        .MemCE_n(a_ce_n), .MemWE_n(a_we_n), .MemOE_n(a_oe_n), .MemADV_n(a_adv_n),
        .MemLB_n(a_lb_n), .MemUB_n(a_ub_n)
    );

    cellram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(8), .LATENCY(LAT)) dut_b (
        .CLK(clk_i), .RSTN(rstn), .Start(start), .Write(write), .AddrIn(addr_in),
        .WrData(b_wr_data), .WrAck(b_wr_ack), .RdData(b_rd_data), .RdValid(b_rd_valid),
        .Busy(b_busy), .Done(b_done), .MemAddr(b_addr), .MemDqOut(b_dq_out),
        .MemDqIn(mem_dq_in), .MemDqOE(b_dq_oe), .MemCRE(b_cre), .MemWait(mem_wait),
        .MemCE_n(b_ce_n), .MemWE_n(b_we_n), .MemOE_n(b_oe_n), .MemADV_n(b_adv_n),
        .MemLB_n(b_lb_n), .MemUB_n(b_ub_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] cfg_ctl(input int d);
        if (d == 0)
            return {a_cre, a_ce_n, a_we_n, a_adv_n, a_oe_n, a_dq_oe, a_rd_valid, a_wr_ack, a_done, a_busy};
        return {b_cre, b_ce_n, b_we_n, b_adv_n, b_oe_n, b_dq_oe, b_rd_valid, b_wr_ack, b_done, b_busy};
    endfunction

    task automatic apply_cfg_table();
        for (int r = 0; r < 7; r++) begin
            rstn = cfg_tab[r].rstn;
            @(posedge clk_i); #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("cfg r%0d d%0d ctl", r, d), 32'(cfg_ctl(d)), 32'(cfg_tab[r].ctl));
                if (cfg_tab[r].chk_addr)
                    check($sformatf("cfg r%0d d%0d addr", r, d), 32'(d == 0 ? a_addr : b_addr),
                          32'(d == 0 ? cfg_tab[r].addr_a : cfg_tab[r].addr_b));
                if (cfg_tab[r].chk_zero)
                    check($sformatf("cfg r%0d d%0d data", r, d),
                          d == 0 ? {a_rd_data, a_dq_out} : {b_rd_data, b_dq_out}, 32'd0);
            end
        end
    endtask

    // Transaction-level expectation: XFER cycle i sits at ADDR+LAT+i; a non-stalled cycle
    // yields a beat visible one cycle later; a run of more than WLIM stalls aborts.
    task automatic build_expect(input int d, input int bl);
        int beats, run, i;
        for (int k = 0; k < NC; k++) begin
            exp_beat[d][k] = 1'b0;
            exp_idx[d][k]  = 0;
        end
        beats = 0; run = 0; i = 0;
        while (i < NC - LAT - 2) begin
            if (wpat[i]) begin
                run++;
                if (run > WLIM) break;
            end else begin
                run = 0;
                exp_beat[d][LAT + i + 1] = 1'b1;
                exp_idx[d][LAT + i + 1]  = beats;
                beats++;
                if (beats == bl) break;
            end
            i++;
        end
        done_cyc[d] = LAT + i + 1;
        exp_cnt[d]  = beats;
    endtask

    task automatic check_cycle(input int d, input int k, input bit wr, input logic [AW-1:0] addr);
        logic [8:0] act, exp;
        int dn;
        bit bt;
        dn  = done_cyc[d];
        bt  = exp_beat[d][k];
        exp = {k >= dn, k != 0, !(wr && k < dn), !(!wr && k >= LAT && k < dn),
               (wr && k >= LAT && k < dn), k <= dn, !wr && bt, wr && bt, k == dn};
        act = (d == 0) ? {a_ce_n, a_adv_n, a_we_n, a_oe_n, a_dq_oe, a_busy, a_rd_valid, a_wr_ack, a_done}
                       : {b_ce_n, b_adv_n, b_we_n, b_oe_n, b_dq_oe, b_busy, b_rd_valid, b_wr_ack, b_done};
        check($sformatf("burst d%0d k%0d ctl", d, k), 32'(act), 32'(exp));
        if (act[2] || act[1]) obs_cnt[d]++;
        if (bt && !wr)
            check($sformatf("burst d%0d k%0d rdata", d, k), 32'(d == 0 ? a_rd_data : b_rd_data), 32'(din[k-1]));
        if (bt && wr)
            check($sformatf("burst d%0d k%0d wdata", d, k), 32'(d == 0 ? a_dq_out : b_dq_out),
                  32'(wdata[d][exp_idx[d][k]]));
        if (k == 0)
            check($sformatf("burst d%0d addr", d), 32'(d == 0 ? a_addr : b_addr), 32'(addr));
    endtask

    task automatic run_burst(input bit wr, input logic [AW-1:0] addr, input int start_at);
        int last;
        build_expect(0, 4);
        build_expect(1, 8);
        last = ((done_cyc[0] > done_cyc[1]) ? done_cyc[0] : done_cyc[1]) + 3;
        for (int d = 0; d < 2; d++) begin
            obs_cnt[d] = 0;
            wr_idx[d]  = 0;
        end
        a_wr_data = wdata[0][0];
        b_wr_data = wdata[1][0];
        write = wr; addr_in = addr; start = 1'b1; mem_wait = 1'b0;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk_i); #1;
            start = 1'b0;
            check_cycle(0, k, wr, addr);
            check_cycle(1, k, wr, addr);
            if (a_wr_ack && wr_idx[0] < 15) wr_idx[0]++;
            if (b_wr_ack && wr_idx[1] < 15) wr_idx[1]++;
            a_wr_data = wdata[0][wr_idx[0]];
            b_wr_data = wdata[1][wr_idx[1]];
            if (k == start_at) begin
                start = 1'b1; write = ~wr; addr_in = ~addr;
            end
            mem_wait  = (k >= LAT && k - LAT < NC) ? wpat[k - LAT] : 1'b0;
            mem_dq_in = DW'($urandom);
            din[k]    = mem_dq_in;
        end
        for (int d = 0; d < 2; d++)
            check($sformatf("burst d%0d beat count", d), 32'(obs_cnt[d]), 32'(exp_cnt[d]));
    endtask

    task automatic fill_wdata();
        for (int d = 0; d < 2; d++)
            for (int j = 0; j < 16; j++)
                wdata[d][j] = DW'($urandom);
    endtask

    task automatic set_wpat(input bit v);
        for (int i = 0; i < NC; i++) wpat[i] = v;
    endtask

    initial begin
        // BCR(3,4) = sel 10 @19:18, latency 3 @13:11, wait active-high @10, length code 001.
        cfg_tab[0] = '{1'b0, 10'b0111100001, 1'b1, 1'b1, 23'h000000, 23'h000000};
        cfg_tab[1] = '{1'b0, 10'b0111100001, 1'b1, 1'b1, 23'h000000, 23'h000000};
        cfg_tab[2] = '{1'b1, 10'b1000100001, 1'b1, 1'b0, 23'h081C01, 23'h081C02};
        cfg_tab[3] = '{1'b1, 10'b0111100001, 1'b0, 1'b0, 23'h000000, 23'h000000};
        cfg_tab[4] = '{1'b1, 10'b0111100001, 1'b0, 1'b0, 23'h000000, 23'h000000};
        cfg_tab[5] = '{1'b1, 10'b0111100000, 1'b0, 1'b0, 23'h000000, 23'h000000};
        cfg_tab[6] = '{1'b1, 10'b0111100000, 1'b0, 1'b0, 23'h000000, 23'h000000};
        fill_wdata();
        a_wr_data = '0;
        b_wr_data = '0;

        apply_cfg_table();

        // Plain read: memory transfer cycles start at ADDR+3, registered RdValid follows.
        set_wpat(1'b0);
        run_burst(1'b0, 23'h012345, -1);

        // Write with a two-cycle stall on the third beat.
        fill_wdata();
        set_wpat(1'b0);
        wpat[2] = 1'b1;
        wpat[3] = 1'b1;
        run_burst(1'b1, 23'h7ABCD0, -1);

        // Start pulsed mid-transfer must be ignored.
        set_wpat(1'b0);
        run_burst(1'b0, 23'h000100, LAT + 1);

        // Stuck wait: abort after the stall limit.
        set_wpat(1'b1);
        run_burst(1'b0, 23'h155555, -1);
        check("abort short burst d0", 32'(obs_cnt[0] < 4), 32'd1);
        check("abort short burst d1", 32'(obs_cnt[1] < 8), 32'd1);

        // Reset during the second read beat, then full reconfiguration.
        start = 1'b1; write = 1'b0; addr_in = 23'h003000;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk_i); #1;
            start = 1'b0;
            if (k == 5) begin
                check("midreset beat2 valid", 32'(a_rd_valid), 32'd1);
                check("midreset beat2 data", 32'(a_rd_data), 32'(din[4]));
            end
            mem_wait  = 1'b0;
            mem_dq_in = DW'($urandom);
            din[k]    = mem_dq_in;
        end
        apply_cfg_table();

        for (int n = 0; n < 12; n++) begin
            bit wr;
            int sa;
            wr = 1'($urandom_range(0, 1));
            for (int i = 0; i < NC; i++) wpat[i] = ($urandom_range(0, 3) == 0);
            if (n == 7)
                for (int i = 2; i < 80; i++) wpat[i] = 1'b1;
            fill_wdata();
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1;
            run_burst(wr, AW'($urandom), sa);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
